// File: rtl/dual_ram_arbiter_pkg.sv
// dual_ram_arbiter_pkg: shared widths, requester limit and one-hot decode for the RAM arbiter.
package dual_ram_arbiter_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 12;
  localparam int NREQ_MAX = 8;
  localparam int IW = $clog2(NREQ_MAX);
  function automatic logic [IW-1:0] onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ_MAX; i++) idx = oh[i] ? (idx | IW'(i)) : idx;
    return idx;
  endfunction
endpackage

// File: rtl/dual_ram_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin grant, first requester at or after the pointer wins.
module rr_arbiter
  import dual_ram_arbiter_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [PW-1:0] ptr, nxt;
  logic [NREQ-1:0] hi, pick;
  logic [IW-1:0] g;
  // Requests at or above ptr take precedence; otherwise wrap to the lowest requester.
  always_comb begin
    hi = req & ~((NREQ'(1) << ptr) - NREQ'(1));
    pick = |hi ? hi : req;
    gnt = pick & (~pick + NREQ'(1));
    g = onehot_to_idx(NREQ_MAX'(gnt));
    nxt = int'(g) == NREQ - 1 ? '0 : PW'(int'(g) + 1);
  end
  always_ff @(posedge clk)
    if (rst) ptr <= '0;
    else if (|gnt) ptr <= nxt;
endmodule

// File: rtl/dual_ram_arbiter.sv
// dual_ram_arbiter: independent round-robin write/read arbitration onto one dual-port RAM.
module dual_ram_arbiter
  import dual_ram_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NREQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_wr_i,
  input  logic [NREQ*AW-1:0] req_waddr_i,
  input  logic [NREQ*DW-1:0] req_wdata_i,
  output logic [NREQ-1:0]    req_wgnt_o,
  input  logic [NREQ-1:0]    req_rd_i,
  input  logic [NREQ*AW-1:0] req_raddr_i,
  output logic [NREQ-1:0]    req_rgnt_o,
  output logic [NREQ-1:0]    req_rvalid_o,
  output logic [DW-1:0]      req_rdata_o,
  output logic               ram_w_en_o,
  output logic [AW-1:0]      ram_w_addr_o,
  output logic [DW-1:0]      ram_w_data_o,
  output logic               ram_r_en_o,
  output logic [AW-1:0]      ram_r_addr_o,
  input  logic [DW-1:0]      ram_r_data_i
);
  logic [NREQ-1:0] wreq, rreq, rtag;
  assign wreq = rst ? '0 : req_wr_i;
  assign rreq = rst ? '0 : req_rd_i;
  rr_arbiter #(.NREQ(NREQ)) u_wr (.clk(clk), .rst(rst), .req(wreq), .gnt(req_wgnt_o));
  rr_arbiter #(.NREQ(NREQ)) u_rd (.clk(clk), .rst(rst), .req(rreq), .gnt(req_rgnt_o));
  // Grants are one-hot or zero, so an AND-OR mux yields zero when idle.
  always_comb begin
    ram_w_addr_o = '0;
    ram_w_data_o = '0;
    ram_r_addr_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      ram_w_addr_o = ram_w_addr_o | ({AW{req_wgnt_o[k]}} & req_waddr_i[k*AW +: AW]);
      ram_w_data_o = ram_w_data_o | ({DW{req_wgnt_o[k]}} & req_wdata_i[k*DW +: DW]);
      ram_r_addr_o = ram_r_addr_o | ({AW{req_rgnt_o[k]}} & req_raddr_i[k*AW +: AW]);
    end
  end
  assign ram_w_en_o = |req_wgnt_o;
  assign ram_r_en_o = |req_rgnt_o;
  always_ff @(posedge clk) rtag <= rst ? '0 : req_rgnt_o;
  assign req_rvalid_o = rtag;
  assign req_rdata_o = ram_r_data_i;
endmodule

// File: tb/tb_dual_ram_arbiter.sv
// tb_dual_ram_arbiter: directed checks of arbitration, RAM drive and read return.
module tb_dual_ram_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;

  logic [1:0] wr = '0, rd = '0, wgnt, rgnt, rvalid;
  logic [23:0] waddr = '0, raddr = '0;
  logic [63:0] wdata = '0;
  logic [31:0] rdata, w_data, ram_rdata = '0;
  logic [11:0] w_addr, r_addr;
  logic w_en, r_en;
  dual_ram_arbiter #(.DW(32), .AW(12), .NREQ(2)) dut (
    .clk(clk), .rst(rst), .req_wr_i(wr), .req_waddr_i(waddr), .req_wdata_i(wdata),
    .req_wgnt_o(wgnt), .req_rd_i(rd), .req_raddr_i(raddr), .req_rgnt_o(rgnt),
    .req_rvalid_o(rvalid), .req_rdata_o(rdata), .ram_w_en_o(w_en), .ram_w_addr_o(w_addr),
    .ram_w_data_o(w_data), .ram_r_en_o(r_en), .ram_r_addr_o(r_addr), .ram_r_data_i(ram_rdata));

  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (r_en) ram_rdata <= (w_en && w_addr == r_addr) ? w_data : mem[r_addr];
    if (w_en) mem[w_addr] <= w_data;
  end

  logic [2:0] wr3 = '0, rd3 = '0, wgnt3, rgnt3, rvalid3;
  logic [35:0] waddr3 = '0, raddr3 = '0;
  logic [95:0] wdata3 = '0;
  logic [31:0] rdata3, w_data3, ram_rdata3 = '0;
  logic [11:0] w_addr3, r_addr3;
  logic w_en3, r_en3;
  dual_ram_arbiter #(.DW(32), .AW(12), .NREQ(3)) dut3 (
    .clk(clk), .rst(rst), .req_wr_i(wr3), .req_waddr_i(waddr3), .req_wdata_i(wdata3),
    .req_wgnt_o(wgnt3), .req_rd_i(rd3), .req_raddr_i(raddr3), .req_rgnt_o(rgnt3),
    .req_rvalid_o(rvalid3), .req_rdata_o(rdata3), .ram_w_en_o(w_en3), .ram_w_addr_o(w_addr3),
    .ram_w_data_o(w_data3), .ram_r_en_o(r_en3), .ram_r_addr_o(r_addr3), .ram_r_data_i(ram_rdata3));

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; wr = '0; rd = '0; wr3 = '0; rd3 = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; wr = 2'b11; rd = 2'b11; wr3 = 3'b111;
    #1;
    n_cmp++; if (rgnt !== 2'b00 || wgnt !== 2'b00) begin n_err++; $display("FAIL rst_gnt got w=%b r=%b want 00/00", wgnt, rgnt); end
    n_cmp++; if (w_en !== 1'b0 || r_en !== 1'b0) begin n_err++; $display("FAIL rst_en got w=%b r=%b want 0/0", w_en, r_en); end
    n_cmp++; if (w_addr !== 12'h0 || r_addr !== 12'h0 || w_data !== 32'h0) begin n_err++; $display("FAIL rst_bus got %h %h %h want 0", w_addr, r_addr, w_data); end
    n_cmp++; if (wgnt3 !== 3'b000) begin n_err++; $display("FAIL rst_gnt3 got %b want 000", wgnt3); end
    @(negedge clk);
    #1;
    n_cmp++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL rst_rvalid got %b want 00", rvalid); end
    wr = '0; rd = '0; wr3 = '0;
    @(negedge clk);
    rst = 1'b0; wr = 2'b01; waddr[11:0] = 12'h010; wdata[31:0] = 32'hDEADBEEF;
    #1;
    n_cmp++; if (wgnt !== 2'b01 || w_en !== 1'b1) begin n_err++; $display("FAIL preload_wgnt got %b/%b want 01/1", wgnt, w_en); end
    @(negedge clk);
    wr = '0; rd = 2'b01; raddr[11:0] = 12'h010;
    #1;
    n_cmp++; if (rgnt !== 2'b01 || r_en !== 1'b1) begin n_err++; $display("FAIL t1_rgnt got %b/%b want 01/1", rgnt, r_en); end
    n_cmp++; if (r_addr !== 12'h010) begin n_err++; $display("FAIL t1_raddr got %h want 010", r_addr); end
    @(negedge clk);
    rd = '0;
    #1;
    n_cmp++; if (rvalid !== 2'b01) begin n_err++; $display("FAIL t1_rvalid got %b want 01", rvalid); end
    n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL t1_rdata got %h want deadbeef", rdata); end
    n_cmp++; if (rgnt !== 2'b00) begin n_err++; $display("FAIL t1_idle got %b want 00", rgnt); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] prev = 2'b00;
    do_reset();
    rd = 2'b11; raddr = {12'h020, 12'h010};
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (rgnt !== exp[i]) begin n_err++; $display("FAIL rr_gnt[%0d] got %b want %b", i, rgnt, exp[i]); end
      n_cmp++; if (rvalid !== prev) begin n_err++; $display("FAIL rr_rvalid[%0d] got %b want %b", i, rvalid, prev); end
      prev = exp[i];
      @(negedge clk);
    end
    rd = '0;
    #1;
    n_cmp++; if (rvalid !== 2'b10) begin n_err++; $display("FAIL rr_rvalid_last got %b want 10", rvalid); end
  endtask

  task automatic test_parallel;
    do_reset();
    wr = 2'b01; waddr[11:0] = 12'h020; wdata[31:0] = 32'h5;
    rd = 2'b10; raddr[23:12] = 12'h020;
    #1;
    n_cmp++; if (wgnt !== 2'b01 || rgnt !== 2'b10) begin n_err++; $display("FAIL par_gnt got w=%b r=%b want 01/10", wgnt, rgnt); end
    n_cmp++; if (w_addr !== 12'h020 || w_data !== 32'h5 || r_addr !== 12'h020) begin n_err++; $display("FAIL par_bus got %h %h %h want 020 5 020", w_addr, w_data, r_addr); end
    @(negedge clk);
    wr = '0; rd = '0;
    #1;
    n_cmp++; if (rvalid !== 2'b10) begin n_err++; $display("FAIL par_rvalid got %b want 10", rvalid); end
    n_cmp++; if (rdata !== 32'h5) begin n_err++; $display("FAIL par_rdata got %h want 5", rdata); end
  endtask

  task automatic test_abandon;
    do_reset();
    rd = 2'b11;
    #1;
    n_cmp++; if (rgnt !== 2'b01) begin n_err++; $display("FAIL ab_gnt got %b want 01", rgnt); end
    @(negedge clk);
    rd = '0;
    #1;
    n_cmp++; if (rgnt !== 2'b00 || rvalid !== 2'b01) begin n_err++; $display("FAIL ab_drop got g=%b v=%b want 00/01", rgnt, rvalid); end
    n_cmp++; if (dut.u_rd.ptr !== 1'b1) begin n_err++; $display("FAIL ab_rptr got %b want 1", dut.u_rd.ptr); end
    @(negedge clk);
    #1;
    n_cmp++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL ab_rvalid got %b want 00", rvalid); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    rd = 2'b01; wr = 2'b10;
    #1;
    n_cmp++; if (rgnt !== 2'b01 || wgnt !== 2'b10) begin n_err++; $display("FAIL mid_gnt got r=%b w=%b want 01/10", rgnt, wgnt); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (rgnt !== 2'b00 || wgnt !== 2'b00 || r_en !== 1'b0) begin n_err++; $display("FAIL mid_gate got r=%b w=%b en=%b want 00/00/0", rgnt, wgnt, r_en); end
    @(negedge clk);
    #1;
    n_cmp++; if (rvalid !== 2'b00) begin n_err++; $display("FAIL mid_rvalid got %b want 00", rvalid); end
    n_cmp++; if (dut.u_rd.ptr !== 1'b0 || dut.u_wr.ptr !== 1'b0) begin n_err++; $display("FAIL mid_ptr got r=%b w=%b want 0/0", dut.u_rd.ptr, dut.u_wr.ptr); end
    n_cmp++; if (rgnt !== 2'b00 || wgnt !== 2'b00) begin n_err++; $display("FAIL mid_hold got r=%b w=%b want 00/00", rgnt, wgnt); end
    @(negedge clk);
    rst = 1'b0; rd = '0; wr = '0;
  endtask

  task automatic test_fairness3;
    logic [2:0] exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [31:0] dexp [4] = '{32'hA, 32'hB, 32'hC, 32'hA};
    do_reset();
    wr3 = 3'b111; wdata3 = {32'hC, 32'hB, 32'hA}; waddr3 = {12'h300, 12'h200, 12'h100};
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (wgnt3 !== exp[i]) begin n_err++; $display("FAIL f3_gnt[%0d] got %b want %b", i, wgnt3, exp[i]); end
      n_cmp++; if (w_data3 !== dexp[i]) begin n_err++; $display("FAIL f3_data[%0d] got %h want %h", i, w_data3, dexp[i]); end
      @(negedge clk);
    end
    wr3 = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_parallel();
    test_abandon();
    test_reset_mid();
    test_fairness3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
